// File: rtl/demux_buf_pkg.sv
// ============================================================================
// Module      : demux_pkg
// Description : Shared channel count, select type and select decode for the
//               demux_buf slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int NCHAN = 8;
    localparam int SELW  = 3;

    typedef logic [SELW-1:0] sel_t;

    // One-hot decode of a channel select.
    function automatic logic [NCHAN-1:0] sel_onehot(input sel_t sel);
        logic [NCHAN-1:0] hot;
        hot      = '0;
        hot[sel] = 1'b1;
        return hot;
    endfunction

endpackage : demux_pkg

`default_nettype wire

// File: rtl/demux_buf_if.sv
// ============================================================================
// Module      : demux_buf_if
// Description : Producer / eight-consumer handshake bundle for demux_buf.
//               The bcast signal exists only when DEMUX_BROADCAST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface demux_buf_if
    import demux_pkg::*;
#(
    parameter int nBit = 8
);
    logic [nBit-1:0]  din;
    sel_t             Sel;
    logic             in_valid;
    logic             in_ready;
`ifdef DEMUX_BROADCAST_EN
    logic             bcast;
`endif
    logic [nBit-1:0]  out0;
    logic [nBit-1:0]  out1;
    logic [nBit-1:0]  out2;
    logic [nBit-1:0]  out3;
    logic [nBit-1:0]  out4;
    logic [nBit-1:0]  out5;
    logic [nBit-1:0]  out6;
    logic [nBit-1:0]  out7;
    logic [NCHAN-1:0] out_valid;
    logic [NCHAN-1:0] out_ready;

`ifdef DEMUX_BROADCAST_EN
    modport slave (
        input  din, Sel, in_valid, bcast, out_ready,
        output in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid
    );
    modport master (
        output din, Sel, in_valid, bcast, out_ready,
        input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid
    );
`else
    modport slave (
        input  din, Sel, in_valid, out_ready,
        output in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid
    );
    modport master (
        output din, Sel, in_valid, out_ready,
        input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid
    );
`endif

endinterface : demux_buf_if

`default_nettype wire

// File: rtl/demux_buf_slot.sv
// ============================================================================
// Module      : demux_slot
// Description : One-entry output buffer; load wins over a same-cycle drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_slot #(
    parameter int nBit = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            load,
    input  wire logic [nBit-1:0] d,
    output logic      [nBit-1:0] q,
    output logic                 valid,
    input  wire logic            ready
);

    logic [nBit-1:0] r_data_q;
    logic [nBit-1:0] w_data_d;
    logic            r_valid_q;
    logic            w_valid_d;

    always_comb begin
        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;
        if (load) begin
            w_data_d  = d;
            w_valid_d = 1'b1;
        end else if (r_valid_q && ready) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign q     = r_data_q;
    assign valid = r_valid_q;

endmodule : demux_slot

`default_nettype wire

// File: rtl/demux_buf.sv
// ============================================================================
// Module      : demux_buf
// Description : Registered 1-to-8 demultiplexer with a one-entry buffer per
//               channel. Optional broadcast under DEMUX_BROADCAST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_buf
    import demux_pkg::*;
#(
    parameter int nBit = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    demux_buf_if.slave    bus
);

    logic [NCHAN-1:0] w_valid;
    logic [NCHAN-1:0] w_slot_free;
    logic [NCHAN-1:0] w_load;
    logic             w_bcast;
    logic             w_in_ready;
    logic [nBit-1:0]  w_q [NCHAN];

`ifdef DEMUX_BROADCAST_EN
    assign w_bcast = bus.bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // A slot can take a word if it is empty or being drained this cycle.
    always_comb begin
        w_slot_free = ~w_valid | bus.out_ready;
        w_in_ready  = w_bcast ? (&w_slot_free) : w_slot_free[bus.Sel];
        w_load      = '0;
        if (bus.in_valid && w_in_ready) begin
            w_load = w_bcast ? {NCHAN{1'b1}} : sel_onehot(bus.Sel);
        end
    end

    generate
        for (genvar k = 0; k < NCHAN; k++) begin : g_slot
            demux_slot #(
                .nBit (nBit)
            ) u_slot (
                .clk   (clk),
                .rst   (rst),
                .load  (w_load[k]),
                .d     (bus.din),
                .q     (w_q[k]),
                .valid (w_valid[k]),
                .ready (bus.out_ready[k])
            );
        end
    endgenerate

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_valid;
    assign bus.out0      = w_q[0];
    assign bus.out1      = w_q[1];
    assign bus.out2      = w_q[2];
    assign bus.out3      = w_q[3];
    assign bus.out4      = w_q[4];
    assign bus.out5      = w_q[5];
    assign bus.out6      = w_q[6];
    assign bus.out7      = w_q[7];

endmodule : demux_buf

`default_nettype wire

// File: tb/tb_demux_buf.sv
// ============================================================================
// Module      : tb_demux_buf
// Description : Directed self-checking bench for demux_buf (broadcast steps
//               included when DEMUX_BROADCAST_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_buf;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    demux_buf_if #(.nBit(8)) bus ();

    demux_buf #(
        .nBit (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] out_k(input int k);
        case (k)
            0:       return bus.out0;
            1:       return bus.out1;
            2:       return bus.out2;
            3:       return bus.out3;
            4:       return bus.out4;
            5:       return bus.out5;
            6:       return bus.out6;
            default: return bus.out7;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input logic [7:0] val);
        bus.Sel      = 3'(ch);
        bus.din      = val;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst           = 1'b1;
        bus.din       = '0;
        bus.Sel       = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = '0;
`ifdef DEMUX_BROADCAST_EN
        bus.bcast     = 1'b0;
`endif
        step();
        step();
        chk("reset_out_valid", 32'(bus.out_valid), 32'h00);
        for (int k = 0; k < 8; k++) chk($sformatf("reset_out%0d", k), 32'(out_k(k)), 32'h00);
        chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
        rst = 1'b0;
        step();

        // Single route to channel 3
        load(3, 8'hA5);
        chk("route_out3", 32'(bus.out3), 32'hA5);
        chk("route_out_valid", 32'(bus.out_valid), 32'h08);
        chk("route_out2", 32'(bus.out2), 32'h00);
        chk("route_out4", 32'(bus.out4), 32'h00);

        // Backpressure on channel 6
        load(6, 8'h77);
        chk("bp_prefill_valid", 32'(bus.out_valid), 32'h48);
        bus.Sel = 3'd6; bus.din = 8'h3C; bus.in_valid = 1'b1; bus.out_ready = 8'h00;
        #1;
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
        bus.Sel = 3'd5;
        #1;
        chk("bp_other_chan_ready", 32'(bus.in_ready), 32'h1);
        bus.Sel = 3'd6;
        step();
        chk("bp_out6_held", 32'(bus.out6), 32'h77);
        chk("bp_valid_held", 32'(bus.out_valid), 32'h48);
        bus.out_ready = 8'h40;
        #1;
        chk("bp_in_ready_drain", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0; bus.out_ready = 8'h00;
        chk("bp_out6_refill", 32'(bus.out6), 32'h3C);
        chk("bp_valid_refill", 32'(bus.out_valid), 32'h48);

        // Drain 3 and 6; data stays put
        bus.out_ready = 8'h48;
        step();
        bus.out_ready = 8'h00;
        chk("drain_valid", 32'(bus.out_valid), 32'h00);
        chk("drain_out6_kept", 32'(bus.out6), 32'h3C);

        // Streaming into channel 0 with consumer always ready
        bus.Sel = 3'd0; bus.out_ready = 8'h01;
        for (int i = 1; i <= 16; i++) begin
            bus.din = 8'(i); bus.in_valid = 1'b1;
            #1;
            chk($sformatf("stream_in_ready_%0d", i), 32'(bus.in_ready), 32'h1);
            step();
            chk($sformatf("stream_out0_%0d", i), 32'(bus.out0), 32'(i));
            chk($sformatf("stream_valid_%0d", i), 32'(bus.out_valid), 32'h01);
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 8'h00;
        chk("stream_drained", 32'(bus.out_valid), 32'h00);

        // Parallel drain of 1 and 7 while loading 4
        load(1, 8'h22);
        load(7, 8'h33);
        chk("par_prefill", 32'(bus.out_valid), 32'h82);
        bus.Sel = 3'd4; bus.din = 8'h11; bus.in_valid = 1'b1; bus.out_ready = 8'h82;
        step();
        bus.in_valid = 1'b0; bus.out_ready = 8'h00;
        chk("par_valid", 32'(bus.out_valid), 32'h10);
        chk("par_out4", 32'(bus.out4), 32'h11);
        chk("par_out1_kept", 32'(bus.out1), 32'h22);

        // Asynchronous reset mid-cycle with slots 2 and 5 full
        load(2, 8'h55);
        load(5, 8'hAA);
        chk("rst_prefill", 32'(bus.out_valid), 32'h34);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(bus.out_valid), 32'h00);
        chk("rst_async_out2", 32'(bus.out2), 32'h00);
        chk("rst_async_out5", 32'(bus.out5), 32'h00);
        chk("rst_async_out4", 32'(bus.out4), 32'h00);
        chk("rst_async_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        rst = 1'b0;
        step();

`ifdef DEMUX_BROADCAST_EN
        bus.bcast = 1'b1; bus.din = 8'hFF; bus.in_valid = 1'b1; bus.Sel = 3'd3;
        #1;
        chk("bc_in_ready_empty", 32'(bus.in_ready), 32'h1);
        step();
        bus.bcast = 1'b0; bus.in_valid = 1'b0;
        chk("bc_valid", 32'(bus.out_valid), 32'hFF);
        for (int k = 0; k < 8; k++) chk($sformatf("bc_out%0d", k), 32'(out_k(k)), 32'hFF);
        bus.out_ready = 8'hFF;
        step();
        bus.out_ready = 8'h00;
        load(2, 8'h01);
        bus.bcast = 1'b1; bus.in_valid = 1'b1; bus.Sel = 3'd0;
        #1;
        chk("bc_blocked", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 8'hFB;
        #1;
        chk("bc_blocked_others_ready", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 8'h04;
        #1;
        chk("bc_unblocked", 32'(bus.in_ready), 32'h1);
        bus.in_valid = 1'b0; bus.bcast = 1'b0; bus.out_ready = 8'h00;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_demux_buf

`default_nettype wire
